// File: rtl/multi_change_detector_pkg.sv
// Shared mode encoding and the commit qualification rule for the multi-channel
// change detector.
package elev_detect_pkg;

    localparam logic [1:0] MODE_ANY = 2'd0;
    localparam logic [1:0] MODE_INC = 2'd1;
    localparam logic [1:0] MODE_DEC = 2'd2;
    localparam logic [1:0] MODE_OFF = 2'd3;

    // Operand width of qualifies(); channel values are zero-extended into it.
    localparam int QUAL_W = 32;

    function automatic logic qualifies(input logic [1:0]        mode,
                                       input logic [QUAL_W-1:0] old_v,
                                       input logic [QUAL_W-1:0] new_v);
        case (mode)
            MODE_ANY: return 1'b1;
            MODE_INC: return new_v > old_v;
            MODE_DEC: return new_v < old_v;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_change_detector_filter.sv
// One monitored channel: stability filter, mode qualification and the pending
// event record with its sticky overflow flag.
module change_filter_ch
    import elev_detect_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_val,
    input  logic [1:0]       mode,
    input  logic             load_clr,
    input  logic             clr_overflow,
    output logic             raw_diff,
    output logic             pending,
    output logic             overflow,
    output logic [WIDTH-1:0] rec_old,
    output logic [WIDTH-1:0] rec_new
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] rec_old_q, rec_old_d;
    logic [WIDTH-1:0] rec_new_q, rec_new_d;

    logic [CNT_W-1:0] count_inc;
    logic             commit;
    logic             qual;
    logic             coalesce;

    always_comb begin
        stable_d  = stable_q;
        cand_d    = cand_q;
        count_d   = count_q;
        count_inc = '0;
        commit    = 1'b0;
        if (in_val == stable_q) begin
            count_d = '0;
        end else begin
            if (in_val == cand_q) begin
                count_inc = count_q + CNT_W'(1);
            end else begin
                cand_d    = in_val;
                count_inc = CNT_W'(1);
            end
            if (count_inc == CNT_TARGET) begin
                commit   = 1'b1;
                stable_d = in_val;
                count_d  = '0;
            end else begin
                count_d = count_inc;
            end
        end
    end

    assign qual = commit && qualifies(mode, QUAL_W'(stable_q), QUAL_W'(in_val));
    // A record being moved to the output slot this edge frees the entry, so a
    // simultaneous commit starts a fresh record instead of coalescing.
    assign coalesce = qual && pending_q && !load_clr;

    always_comb begin
        pending_d  = pending_q && !load_clr;
        rec_old_d  = rec_old_q;
        rec_new_d  = rec_new_q;
        if (qual) begin
            pending_d = 1'b1;
            rec_new_d = in_val;
            if (!coalesce) begin
                rec_old_d = stable_q;
            end
        end
        overflow_d = (overflow_q && !clr_overflow) || coalesce;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q   <= '0;
            cand_q     <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            rec_old_q  <= '0;
            rec_new_q  <= '0;
        end else begin
            stable_q   <= stable_d;
            cand_q     <= cand_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            rec_old_q  <= rec_old_d;
            rec_new_q  <= rec_new_d;
        end
    end

    assign raw_diff = (in_val != stable_q);
    assign pending  = pending_q;
    assign overflow = overflow_q;
    assign rec_old  = rec_old_q;
    assign rec_new  = rec_new_q;

endmodule

// File: rtl/multi_change_detector.sv
// Multi-channel debounced change detector: per-channel filters feed a
// round-robin arbiter that fills a single valid/ready output slot.
module multi_change_detector
    import elev_detect_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [CHANNELS*WIDTH-1:0]                       in_bus,
    input  logic [1:0]                                      mode,
    input  logic                                            evt_ready,
    input  logic                                            clr_overflow,
    output logic                                            evt_valid,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] evt_chan,
    output logic [WIDTH-1:0]                                evt_old,
    output logic [WIDTH-1:0]                                evt_new,
    output logic [CHANNELS-1:0]                             raw_diff,
    output logic [CHANNELS-1:0]                             pending,
    output logic [CHANNELS-1:0]                             overflow
);

    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0]    rec_old [CHANNELS];
    logic [WIDTH-1:0]    rec_new [CHANNELS];
    logic [CHANNELS-1:0] load_clr;

    logic             evt_valid_q, evt_valid_d;
    logic [CHW-1:0]   evt_chan_q, evt_chan_d;
    logic [WIDTH-1:0] evt_old_q, evt_old_d;
    logic [WIDTH-1:0] evt_new_q, evt_new_d;
    logic [CHW-1:0]   last_grant_q, last_grant_d;

    logic             grant_vld;
    logic [CHW-1:0]   grant_idx;
    logic [CHW-1:0]   cidx;
    int               cand_idx;
    logic             slot_free;
    logic             load;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        change_filter_ch #(
            .WIDTH        (WIDTH),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_filter (
            .clk         (clk),
            .rst         (rst),
            .in_val      (in_bus[c*WIDTH +: WIDTH]),
            .mode        (mode),
            .load_clr    (load_clr[c]),
            .clr_overflow(clr_overflow),
            .raw_diff    (raw_diff[c]),
            .pending     (pending[c]),
            .overflow    (overflow[c]),
            .rec_old     (rec_old[c]),
            .rec_new     (rec_new[c])
        );
        assign load_clr[c] = load && (grant_idx == CHW'(c));
    end

    // Round-robin: first pending channel strictly after the last grant, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_idx  = 0;
        cidx      = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand_idx = int'(last_grant_q) + k;
            if (cand_idx >= CHANNELS) begin
                cand_idx = cand_idx - CHANNELS;
            end
            cidx = CHW'(cand_idx);
            if (!grant_vld && pending[cidx]) begin
                grant_vld = 1'b1;
                grant_idx = cidx;
            end
        end
    end

    assign slot_free = !evt_valid_q || evt_ready;
    assign load      = slot_free && grant_vld;

    always_comb begin
        evt_valid_d  = evt_valid_q;
        evt_chan_d   = evt_chan_q;
        evt_old_d    = evt_old_q;
        evt_new_d    = evt_new_q;
        last_grant_d = last_grant_q;
        if (slot_free) begin
            evt_valid_d = grant_vld;
        end
        if (load) begin
            evt_chan_d   = grant_idx;
            evt_old_d    = rec_old[grant_idx];
            evt_new_d    = rec_new[grant_idx];
            last_grant_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_q  <= 1'b0;
            evt_chan_q   <= '0;
            evt_old_q    <= '0;
            evt_new_q    <= '0;
            last_grant_q <= CHW'(CHANNELS - 1);
        end else begin
            evt_valid_q  <= evt_valid_d;
            evt_chan_q   <= evt_chan_d;
            evt_old_q    <= evt_old_d;
            evt_new_q    <= evt_new_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_chan  = evt_chan_q;
    assign evt_old   = evt_old_q;
    assign evt_new   = evt_new_q;

endmodule

// File: tb/tb_multi_change_detector.sv
// Bench for multi_change_detector: directed vector table, hand sequences for
// multi-cycle corner cases, then random traffic against a behavioural model.
module tb_multi_change_detector;

    localparam int CH  = 4;
    localparam int W   = 2;
    localparam int S   = 3;
    localparam int BW  = CH * W;
    localparam int CHW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] in_bus;
    logic [1:0]    mode;
    logic          evt_ready;
    logic          clr_overflow;
    logic          evt_valid;
    logic [CHW-1:0] evt_chan;
    logic [W-1:0]  evt_old;
    logic [W-1:0]  evt_new;
    logic [CH-1:0] raw_diff;
    logic [CH-1:0] pending;
    logic [CH-1:0] overflow;

    always #5 clk = ~clk;

    multi_change_detector #(
        .CHANNELS     (CH),
        .WIDTH        (W),
        .STABLE_CYCLES(S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_bus      (in_bus),
        .mode        (mode),
        .evt_ready   (evt_ready),
        .clr_overflow(clr_overflow),
        .evt_valid   (evt_valid),
        .evt_chan    (evt_chan),
        .evt_old     (evt_old),
        .evt_new     (evt_new),
        .raw_diff    (raw_diff),
        .pending     (pending),
        .overflow    (overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a channel accepts a value once the last S samples all
    // carry it and it differs from the accepted value.
    int            m_stable [CH];
    bit            m_pend   [CH];
    bit            m_ovf    [CH];
    int            m_rold   [CH];
    int            m_rnew   [CH];
    bit            mv;
    int            mchan, mold, mnew, mlg;
    logic [BW-1:0] hist [$];

    function automatic int fld(input logic [BW-1:0] b, input int c);
        logic [BW-1:0] t;
        t = b >> (c * W);
        return int'(t[W-1:0]);
    endfunction

    task automatic model_edge(input logic [BW-1:0] b, input logic [1:0] md,
                              input logic rdy, input logic clr, input logic r);
        bit loaded  [CH];
        bit set_ovf [CH];
        int g;
        if (r) begin
            for (int c = 0; c < CH; c++) begin
                m_stable[c] = 0; m_pend[c] = 0; m_ovf[c] = 0; m_rold[c] = 0; m_rnew[c] = 0;
            end
            mv = 0; mchan = 0; mold = 0; mnew = 0; mlg = CH - 1;
            hist.delete();
            return;
        end
        for (int c = 0; c < CH; c++) begin
            loaded[c] = 0;
            set_ovf[c] = 0;
        end
        if (!mv || rdy) begin
            g = -1;
            for (int k = 1; k <= CH; k++)
                if (g < 0 && m_pend[(mlg + k) % CH]) g = (mlg + k) % CH;
            if (g >= 0) begin
                mv = 1; mchan = g; mold = m_rold[g]; mnew = m_rnew[g]; mlg = g; loaded[g] = 1;
            end else begin
                mv = 0;
            end
        end
        hist.push_back(b);
        if (hist.size() > S) void'(hist.pop_front());
        for (int c = 0; c < CH; c++) begin
            int v, old;
            bit settled, qual, busy;
            v = fld(b, c);
            settled = (hist.size() == S) && (v != m_stable[c]);
            for (int j = 0; j < hist.size(); j++)
                if (fld(hist[j], c) != v) settled = 0;
            busy = m_pend[c] && !loaded[c];
            if (loaded[c]) m_pend[c] = 0;
            if (settled) begin
                old = m_stable[c];
                m_stable[c] = v;
                case (md)
                    2'd0:    qual = 1;
                    2'd1:    qual = (v > old);
                    2'd2:    qual = (v < old);
                    default: qual = 0;
                endcase
                if (qual) begin
                    if (busy) begin
                        set_ovf[c] = 1;
                        m_rnew[c] = v;
                    end else begin
                        m_pend[c] = 1;
                        m_rold[c] = old;
                        m_rnew[c] = v;
                    end
                end
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (clr) m_ovf[c] = 0;
            if (set_ovf[c]) m_ovf[c] = 1;
        end
    endtask

    // One clock: drive, check raw_diff before the edge, advance model, check after.
    task automatic step(input logic [BW-1:0] b, input logic [1:0] md, input logic rdy,
                        input logic clr, input logic r, output logic [CH-1:0] raw_seen);
        logic [CH-1:0] exp_raw, exp_pend, exp_ovf;
        in_bus = b; mode = md; evt_ready = rdy; clr_overflow = clr; rst = r;
        #1;
        raw_seen = raw_diff;
        if (!r) begin
            for (int c = 0; c < CH; c++) exp_raw[c] = (fld(b, c) != m_stable[c]);
            chk("raw_diff", raw_diff, exp_raw);
        end
        model_edge(b, md, rdy, clr, r);
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            exp_pend[c] = m_pend[c];
            exp_ovf[c]  = m_ovf[c];
        end
        chk("evt_valid", evt_valid, mv);
        chk("evt_chan", evt_chan, mchan);
        chk("evt_old", evt_old, mold);
        chk("evt_new", evt_new, mnew);
        chk("pending", pending, exp_pend);
        chk("overflow", overflow, exp_ovf);
    endtask

    logic [CH-1:0] rs;

    task automatic seq(input int n, input logic [BW-1:0] b, input logic rdy);
        for (int i = 0; i < n; i++) step(b, 2'd0, rdy, 1'b0, 1'b0, rs);
    endtask

    task automatic chk_slot(input string name, input logic v, input int ch, input int o, input int n);
        chk({name, "_valid"}, evt_valid, v);
        chk({name, "_chan"}, evt_chan, ch);
        chk({name, "_old"}, evt_old, o);
        chk({name, "_new"}, evt_new, n);
    endtask

    typedef struct {
        logic [BW-1:0] in;
        logic [1:0]    md;
        logic          rdy;
        logic [CH-1:0] raw;
        logic          v;
        logic [1:0]    ch;
        logic [W-1:0]  o;
        logic [W-1:0]  n;
        logic [CH-1:0] pend;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input int cnt, input logic [BW-1:0] b, input logic [1:0] md, input logic rdy,
                       input logic [CH-1:0] raw, input logic v, input logic [1:0] ch,
                       input logic [W-1:0] o, input logic [W-1:0] n, input logic [CH-1:0] pend);
        for (int i = 0; i < cnt; i++) tbl.push_back('{b, md, rdy, raw, v, ch, o, n, pend});
    endtask

    logic [BW-1:0] cur;
    logic [1:0]    rmode;

    initial begin
        // Glitch rejection, then a held change on ch1.
        add(2, 8'h08, 2'd0, 1'b1, 4'b0010, 1'b0, 2'd0, 2'd0, 2'd0, 4'b0000);
        add(2, 8'h00, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 2'd0, 4'b0000);
        add(2, 8'h08, 2'd0, 1'b1, 4'b0010, 1'b0, 2'd0, 2'd0, 2'd0, 4'b0000);
        add(1, 8'h08, 2'd0, 1'b1, 4'b0010, 1'b0, 2'd0, 2'd0, 2'd0, 4'b0010);
        add(1, 8'h08, 2'd0, 1'b1, 4'b0000, 1'b1, 2'd1, 2'd0, 2'd2, 4'b0000);
        add(1, 8'h08, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd1, 2'd0, 2'd2, 4'b0000);
        // Mode filtering on ch0.
        add(3, 8'h09, 2'd3, 1'b1, 4'b0001, 1'b0, 2'd1, 2'd0, 2'd2, 4'b0000);
        add(2, 8'h0B, 2'd1, 1'b1, 4'b0001, 1'b0, 2'd1, 2'd0, 2'd2, 4'b0000);
        add(1, 8'h0B, 2'd1, 1'b1, 4'b0001, 1'b0, 2'd1, 2'd0, 2'd2, 4'b0001);
        add(1, 8'h0B, 2'd1, 1'b1, 4'b0000, 1'b1, 2'd0, 2'd1, 2'd3, 4'b0000);
        add(1, 8'h0B, 2'd1, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd1, 2'd3, 4'b0000);
        add(3, 8'h08, 2'd1, 1'b1, 4'b0001, 1'b0, 2'd0, 2'd1, 2'd3, 4'b0000);
        add(1, 8'h08, 2'd1, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd1, 2'd3, 4'b0000);
        add(3, 8'h0B, 2'd2, 1'b1, 4'b0001, 1'b0, 2'd0, 2'd1, 2'd3, 4'b0000);
        add(2, 8'h08, 2'd2, 1'b1, 4'b0001, 1'b0, 2'd0, 2'd1, 2'd3, 4'b0000);
        add(1, 8'h08, 2'd2, 1'b1, 4'b0001, 1'b0, 2'd0, 2'd1, 2'd3, 4'b0001);
        add(1, 8'h08, 2'd2, 1'b1, 4'b0000, 1'b1, 2'd0, 2'd3, 2'd0, 4'b0000);
        add(1, 8'h08, 2'd2, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd3, 2'd0, 4'b0000);

        step(8'h00, 2'd0, 1'b1, 1'b0, 1'b1, rs);
        chk_slot("reset", 1'b0, 0, 0, 0);
        chk("reset_pending", pending, 0);
        chk("reset_overflow", overflow, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].in, tbl[i].md, tbl[i].rdy, 1'b0, 1'b0, rs);
            chk($sformatf("tbl%0d_raw", i), rs, tbl[i].raw);
            chk_slot($sformatf("tbl%0d", i), tbl[i].v, tbl[i].ch, tbl[i].o, tbl[i].n);
            chk($sformatf("tbl%0d_pending", i), pending, tbl[i].pend);
            chk($sformatf("tbl%0d_overflow", i), overflow, 0);
        end

        // Round-robin after reset: ch0, ch2, ch3 together, then ch0 + ch3.
        step(8'h00, 2'd0, 1'b1, 1'b0, 1'b1, rs);
        seq(3, 8'h51, 1'b1);
        chk("rr_pending", pending, 4'b1101);
        seq(1, 8'h51, 1'b1); chk_slot("rr_a", 1'b1, 0, 0, 1);
        seq(1, 8'h51, 1'b1); chk_slot("rr_b", 1'b1, 2, 0, 1);
        seq(1, 8'h51, 1'b1); chk_slot("rr_c", 1'b1, 3, 0, 1);
        seq(1, 8'h51, 1'b1); chk("rr_idle", evt_valid, 0);
        seq(3, 8'h92, 1'b1);
        seq(1, 8'h92, 1'b1); chk_slot("rr_d", 1'b1, 0, 1, 2);
        seq(1, 8'h92, 1'b1); chk_slot("rr_e", 1'b1, 3, 1, 2);
        seq(1, 8'h92, 1'b1); chk("rr_idle2", evt_valid, 0);

        // Backpressure with coalescing on ch1.
        seq(3, 8'h96, 1'b0); chk("bp_pending1", pending, 4'b0010);
        seq(1, 8'h96, 1'b0); chk_slot("bp_first", 1'b1, 1, 0, 1);
        seq(3, 8'h9A, 1'b0); chk("bp_ovf0", overflow, 0);
        seq(3, 8'h9E, 1'b0);
        chk("bp_pending", pending, 4'b0010);
        chk("bp_ovf", overflow, 4'b0010);
        chk_slot("bp_held", 1'b1, 1, 0, 1);
        seq(1, 8'h9E, 1'b1); chk_slot("bp_merged", 1'b1, 1, 1, 3);
        chk("bp_ovf_sticky", overflow, 4'b0010);
        seq(1, 8'h9E, 1'b1); chk("bp_drained", evt_valid, 0);
        step(8'h9E, 2'd0, 1'b1, 1'b1, 1'b0, rs);
        chk("bp_ovf_clr", overflow, 0);

        // ch2 commits on the edge its earlier record is loaded.
        seq(3, 8'h9F, 1'b0);
        seq(1, 8'hAF, 1'b0); chk_slot("col_hold", 1'b1, 0, 2, 3);
        seq(2, 8'hAF, 1'b0); chk("col_pend", pending, 4'b0100);
        seq(2, 8'hBF, 1'b0);
        seq(1, 8'hBF, 1'b1);
        chk_slot("col_load", 1'b1, 2, 1, 2);
        chk("col_repend", pending, 4'b0100);
        chk("col_noovf", overflow, 0);
        seq(1, 8'hBF, 1'b1); chk_slot("col_next", 1'b1, 2, 2, 3);
        seq(1, 8'hBF, 1'b1); chk("col_idle", evt_valid, 0);

        // Reset while an event is presented.
        seq(3, 8'h3F, 1'b0);
        seq(1, 8'h3F, 1'b0); chk_slot("rmid_pre", 1'b1, 3, 2, 0);
        step(8'h3F, 2'd0, 1'b0, 1'b0, 1'b1, rs);
        chk_slot("rmid_post", 1'b0, 0, 0, 0);
        chk("rmid_pending", pending, 0);
        seq(3, 8'h3F, 1'b0); chk("rmid_pend2", pending, 4'b0111);
        seq(1, 8'h3F, 1'b1); chk_slot("rmid_first", 1'b1, 0, 0, 3);

        // Random traffic against the model.
        cur = 8'h3F;
        rmode = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                int c;
                c = $urandom_range(0, CH - 1);
                cur[c*W +: W] = W'($urandom);
            end
            if ($urandom_range(0, 19) == 0) rmode = 2'($urandom_range(0, 3));
            step(cur, rmode, ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 499) == 0), rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
